i2c_scl_gen: RTL

I2C master SCL timing generator for the 100 MHz fabric clock. It drives the open-drain SCL enable, honours slave clock stretching through a synchronised copy of the bus, and emits single-cycle phase strobes. `scl_fall` feeds the downstream `delay_signal` stage, which turns it into the SDA-change strobe with hold margin. `scl_sample` feeds the receive shifter.

---
 rtl/i2c_pkg.sv | 16 +
 rtl/i2c_scl_gen_sync_2ff.sv | 25 ++
 rtl/i2c_scl_gen.sv | 107 ++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: SCL FSM state encoding and standard timing constants
// for a 100 MHz fabric clock.
package i2c_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOW       = 2'd1,
        WAIT_HIGH = 2'd2,
        HIGH      = 2'd3
    } scl_state_e;

    localparam int I2C_HALF_PERIOD_400K = 125;
    localparam int I2C_HALF_PERIOD_100K = 500;
    localparam int I2C_STRETCH_MAX_DEF  = 10000;

endpackage

// File: rtl/i2c_scl_gen_sync_2ff.sv
// Two-flop synchroniser for asynchronous pad inputs (SCL here, SDA elsewhere);
// both flops reset to a parameterised idle level.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Metastability-settling chain
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/i2c_scl_gen.sv
// I2C master SCL generator: drives the open-drain enable, waits out slave clock
// stretching on the synchronised bus level, and emits registered phase strobes.
module i2c_scl_gen
    import i2c_pkg::*;
#(
    parameter int HALF_PERIOD = I2C_HALF_PERIOD_400K,
    parameter int STRETCH_MAX = I2C_STRETCH_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic scl_in,
    output logic scl_oe,
    output logic scl_fall,
    output logic scl_rise,
    output logic scl_sample,
    output logic busy,
    output logic stretch_err
);

    localparam int CNT_SPAN = (HALF_PERIOD > STRETCH_MAX) ? HALF_PERIOD : STRETCH_MAX;
    localparam int CW       = $clog2(CNT_SPAN);

    localparam logic [CW-1:0] HALF_LAST    = CW'(HALF_PERIOD - 1);
    localparam logic [CW-1:0] STRETCH_LAST = CW'(STRETCH_MAX - 1);
    localparam logic [CW-1:0] SAMPLE_AT    = CW'(HALF_PERIOD / 2);
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO     = CW'(0);

    scl_state_e      state;
    scl_state_e      state_next;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_next;
    logic            scl_s;
    logic            timeout;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_scl_sync (
        .clk (clk),
        .rst (rst),
        .d   (scl_in),
        .q   (scl_s)
    );

    // Next-state decode; a bus that reads high wins over a coincident timeout
    always_comb begin
        state_next = state;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (en) state_next = LOW;
                else    state_next = IDLE;
            end
            LOW: begin
                if (cnt == HALF_LAST) state_next = WAIT_HIGH;
                else                  state_next = LOW;
            end
            WAIT_HIGH: begin
                if (scl_s) begin
                    state_next = HIGH;
                end else if (cnt == STRETCH_LAST) begin
                    state_next = IDLE;
                    timeout    = 1'b1;
                end else begin
                    state_next = WAIT_HIGH;
                end
            end
            HIGH: begin
                if (cnt == HALF_LAST) state_next = en ? LOW : IDLE;
                else                  state_next = HIGH;
            end
            default: state_next = IDLE;
        endcase
    end

    // Phase counter restarts on every state entry and rests at zero in IDLE
    always_comb begin
        cnt_next = cnt + CNT_ONE;
        if (state_next != state || state_next == IDLE) cnt_next = CNT_ZERO;
        else                                           cnt_next = cnt + CNT_ONE;
    end

    // State, counter and outputs registered from the upcoming state so they stay aligned
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= CNT_ZERO;
            scl_oe      <= 1'b0;
            scl_fall    <= 1'b0;
            scl_rise    <= 1'b0;
            scl_sample  <= 1'b0;
            busy        <= 1'b0;
            stretch_err <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            scl_oe      <= (state_next == LOW);
            scl_fall    <= (state_next == LOW)  && (state != LOW);
            scl_rise    <= (state_next == HIGH) && (state != HIGH);
            scl_sample  <= (state_next == HIGH) && (cnt_next == SAMPLE_AT);
            busy        <= (state_next != IDLE);
            stretch_err <= timeout;
        end
    end

endmodule
